// File: rtl/uart_pkg.sv
// Shared constants, byte-FSM state encoding and bit-timing helpers for the UART frame sink.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_e;

  function automatic int unsigned bit_cycles(input int unsigned clkhz, input int unsigned baud);
    return clkhz / baud;
  endfunction

  function automatic int unsigned half_cycles(input int unsigned clkhz, input int unsigned baud);
    return bit_cycles(clkhz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-byte UART receiver: line synchroniser, byte FSM, bit timer and parity check.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BITCYC = 434,
  parameter int unsigned HALF   = 217,
  parameter int unsigned PARITY = PAR_NONE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       ferr,
  output logic       perr,
  output logic       busy
);

  localparam int unsigned CW      = $clog2(BITCYC + 1);
  localparam logic        HAS_PAR = (PARITY != PAR_NONE);
  localparam logic        ODD     = (PARITY == PAR_ODD);

  rx_state_e      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shreg, sh_n, byte_n;
  logic           par_acc, par_n;
  logic           valid_n, ferr_n, perr_n;
  logic           rx_meta, rx_sync, rx_prev;
  logic           fall, tick_half, tick_bit;

  // Two-flop synchroniser plus previous-value flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
      perr       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= sh_n;
      par_acc    <= par_n;
      rx_byte    <= byte_n;
      byte_valid <= valid_n;
      ferr       <= ferr_n;
      perr       <= perr_n;
      busy       <= (state_n != ST_IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    sh_n      = shreg;
    par_n     = par_acc;
    byte_n    = rx_byte;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    perr_n    = 1'b0;
    fall      = rx_prev & ~rx_sync;
    tick_half = (cnt == CW'(HALF - 1));
    tick_bit  = (cnt == CW'(BITCYC - 1));

    case (state)
      // A falling edge can only follow a high line, so a low stop bit re-arms only after recovery.
      ST_IDLE: begin
        if (fall) begin
          state_n = ST_START;
          cnt_n   = '0;
        end
      end
      ST_START: begin
        if (tick_half) begin
          cnt_n = '0;
          if (rx_sync) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            bit_n   = '0;
            par_n   = 1'b0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (tick_bit) begin
          cnt_n = '0;
          sh_n  = {rx_sync, shreg[7:1]};
          par_n = par_acc ^ rx_sync;
          if (bit_idx == 3'd7) begin
            state_n = HAS_PAR ? ST_PAR : ST_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_PAR: begin
        if (tick_bit) begin
          cnt_n = '0;
          if ((par_acc ^ rx_sync) != ODD) begin
            perr_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_STOP;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_STOP: begin
        if (tick_bit) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          if (rx_sync) begin
            valid_n = 1'b1;
            byte_n  = shreg;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_frame_sink.sv
// UART frame sink: assembles FRAMEBYTES received bytes MSB-first and holds the frame on valid/ready.
module uart_frame_sink
  import uart_pkg::*;
#(
  parameter int unsigned CLKHZ        = 50000000,
  parameter int unsigned BAUDRATE     = 115200,
  parameter int unsigned FRAMEBYTES   = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                    iCLOCK,
  input  logic                    iNRESET,
  input  logic                    iRX,
  input  logic                    iREADY,
  output logic                    oRECEPT,
  output logic                    oVALID,
  output logic                    oDONE,
  output logic [8*FRAMEBYTES-1:0] oFDATA,
  output logic                    oFERR,
  output logic                    oPERR,
  output logic                    oTOUT,
  output logic                    oOVERRUN
);

  localparam int unsigned BITCYC = bit_cycles(CLKHZ, BAUDRATE);
  localparam int unsigned HALF   = half_cycles(CLKHZ, BAUDRATE);
  localparam int unsigned FW     = 8 * FRAMEBYTES;
  localparam int unsigned GAPCYC = TIMEOUT_BITS * BITCYC;
  localparam int unsigned GW     = $clog2(GAPCYC + 1);
  localparam int unsigned BCW    = $clog2(FRAMEBYTES + 1);

  logic [7:0]     rx_byte;
  logic           byte_valid, rx_busy;
  logic [FW-1:0]  frame_sr, frame_full;
  logic [BCW-1:0] byte_cnt, byte_cnt_n;
  logic [GW-1:0]  gap;
  logic           complete, accept, gap_run, gap_hit;

  uart_rx_byte #(
    .BITCYC (BITCYC),
    .HALF   (HALF),
    .PARITY (PARITY)
  ) u_rx (
    .clk        (iCLOCK),
    .rst_n      (iNRESET),
    .rx         (iRX),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .ferr       (oFERR),
    .perr       (oPERR),
    .busy       (rx_busy)
  );

  // Frame bookkeeping; the gap timer runs only while a partial frame waits on an idle line.
  always_comb begin
    frame_full = FW'({frame_sr, rx_byte});
    complete   = byte_valid & (byte_cnt == BCW'(FRAMEBYTES - 1));
    accept     = ~oVALID | iREADY;
    gap_run    = ~rx_busy & (byte_valid | (byte_cnt != '0));
    gap_hit    = gap_run & (gap == GW'(GAPCYC - 1));
    byte_cnt_n = byte_cnt;
    if (oFERR | oPERR | gap_hit | complete) begin
      byte_cnt_n = '0;
    end else if (byte_valid) begin
      byte_cnt_n = byte_cnt + BCW'(1);
    end
  end

  always_ff @(posedge iCLOCK or negedge iNRESET) begin
    if (!iNRESET) begin
      frame_sr <= '0;
      byte_cnt <= '0;
      gap      <= '0;
      oRECEPT  <= 1'b0;
      oVALID   <= 1'b0;
      oDONE    <= 1'b0;
      oFDATA   <= '0;
      oTOUT    <= 1'b0;
      oOVERRUN <= 1'b0;
    end else begin
      byte_cnt <= byte_cnt_n;
      if (byte_valid) begin
        frame_sr <= frame_full;
      end
      if (gap_run & ~gap_hit & ~complete & ~oFERR & ~oPERR) begin
        gap <= gap + GW'(1);
      end else begin
        gap <= '0;
      end
      oRECEPT  <= rx_busy | (byte_cnt_n != '0);
      oDONE    <= complete & accept;
      oOVERRUN <= complete & ~accept;
      oTOUT    <= gap_hit;
      // A completing frame wins over acceptance of the held one, keeping oVALID high.
      if (complete & accept) begin
        oFDATA <= frame_full;
        oVALID <= 1'b1;
      end else if (oVALID & iREADY) begin
        oVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_sink.sv
// Randomised self-checking bench for uart_frame_sink: a non-parity and an even-parity instance.
module tb_uart_frame_sink;

  localparam int unsigned CLKHZ = 1600;
  localparam int unsigned BAUD  = 100;
  localparam int unsigned FB    = 8;
  localparam int unsigned TOB   = 20;
  localparam int unsigned B     = CLKHZ / BAUD;
  localparam int unsigned HALF  = B / 2;
  localparam int unsigned TO    = TOB * B;
  localparam int unsigned FW    = 8 * FB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, ready_a = 1'b1;
  logic rx_b = 1'b1, ready_b = 1'b1;
  logic recept_a, valid_a, done_a, ferr_a, perr_a, tout_a, ovr_a;
  logic recept_b, valid_b, done_b, ferr_b, perr_b, tout_b, ovr_b;
  logic [FW-1:0] fdata_a, fdata_b;

  uart_frame_sink #(.CLKHZ(CLKHZ), .BAUDRATE(BAUD), .FRAMEBYTES(FB), .PARITY(0), .TIMEOUT_BITS(TOB)) u_dut_a (
    .iCLOCK(clk), .iNRESET(rst_n), .iRX(rx_a), .iREADY(ready_a),
    .oRECEPT(recept_a), .oVALID(valid_a), .oDONE(done_a), .oFDATA(fdata_a),
    .oFERR(ferr_a), .oPERR(perr_a), .oTOUT(tout_a), .oOVERRUN(ovr_a));

  uart_frame_sink #(.CLKHZ(CLKHZ), .BAUDRATE(BAUD), .FRAMEBYTES(FB), .PARITY(2), .TIMEOUT_BITS(TOB)) u_dut_b (
    .iCLOCK(clk), .iNRESET(rst_n), .iRX(rx_b), .iREADY(ready_b),
    .oRECEPT(recept_b), .oVALID(valid_b), .oDONE(done_b), .oFDATA(fdata_b),
    .oFERR(ferr_b), .oPERR(perr_b), .oTOUT(tout_b), .oOVERRUN(ovr_b));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  // Observed pulse counts.
  int cnt_done[2] = '{0, 0};
  int cnt_ovr[2]  = '{0, 0};
  int cnt_ferr[2] = '{0, 0};
  int cnt_perr[2] = '{0, 0};
  int cnt_tout[2] = '{0, 0};
  int unsigned tout_cyc = 0;

  always @(negedge clk) begin
    if (done_a) cnt_done[0]++;
    if (ovr_a)  cnt_ovr[0]++;
    if (ferr_a) cnt_ferr[0]++;
    if (perr_a) cnt_perr[0]++;
    if (tout_a) begin cnt_tout[0]++; tout_cyc = cyc; end
    if (done_b) cnt_done[1]++;
    if (ovr_b)  cnt_ovr[1]++;
    if (ferr_b) cnt_ferr[1]++;
    if (perr_b) cnt_perr[1]++;
    if (tout_b) cnt_tout[1]++;
  end

  // Reference model state.
  int exp_done[2] = '{0, 0};
  int exp_ovr[2]  = '{0, 0};
  int exp_ferr[2] = '{0, 0};
  int exp_perr[2] = '{0, 0};
  int exp_tout[2] = '{0, 0};
  logic [FW-1:0] exp_fdata[2] = '{'0, '0};
  logic valid_m[2] = '{1'b0, 1'b0};
  logic [7:0] part[2][FB];
  int part_n[2] = '{0, 0};

  logic [7:0] fr[FB];
  logic rec_chk = 1'b0;
  int rec_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic model_byte(input int sel, input logic [7:0] b, input logic stop_v, input logic par_v);
    logic par_ok;
    logic rdy;
    logic [FW-1:0] f;
    par_ok = (sel == 0) || (($countones({b, par_v}) % 2) == 0);
    if (!par_ok) begin
      exp_perr[sel]++;
      part_n[sel] = 0;
    end else if (!stop_v) begin
      exp_ferr[sel]++;
      part_n[sel] = 0;
    end else begin
      part[sel][part_n[sel]] = b;
      part_n[sel]++;
      if (part_n[sel] == FB) begin
        rdy = (sel == 0) ? ready_a : ready_b;
        f = '0;
        for (int i = 0; i < FB; i++) f = (f << 8) | FW'(part[sel][i]);
        if (!valid_m[sel] || rdy) begin
          exp_done[sel]++;
          exp_fdata[sel] = f;
          valid_m[sel] = !rdy;
        end else begin
          exp_ovr[sel]++;
        end
        part_n[sel] = 0;
      end
    end
  endtask

  task automatic drive_bit(input int sel, input logic v);
    if (sel == 0) rx_a = v; else rx_b = v;
    repeat (B) begin
      @(negedge clk);
      if (rec_chk && recept_a !== 1'b1) rec_bad++;
    end
  endtask

  task automatic idle_bits(input int sel, input int n);
    for (int i = 0; i < n; i++) drive_bit(sel, 1'b1);
    if (n * B >= TO && part_n[sel] != 0) begin
      exp_tout[sel]++;
      part_n[sel] = 0;
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop_v, input logic par_v,
                           input bit arm, input bit disarm);
    drive_bit(sel, 1'b0);
    if (arm) rec_chk = (sel == 0);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
    if (sel == 1) drive_bit(sel, par_v);
    if (disarm) rec_chk = 1'b0;
    drive_bit(sel, stop_v);
    model_byte(sel, b, stop_v, par_v);
  endtask

  task automatic send_frame(input int sel, input int gap_max);
    rec_bad = 0;
    for (int i = 0; i < FB; i++) begin
      send_byte(sel, fr[i], 1'b1, ^fr[i], i == 0, i == FB - 1);
      if (i < FB - 1 && gap_max > 0) idle_bits(sel, $urandom_range(gap_max, 0));
    end
    idle_bits(sel, 2);
  endtask

  task automatic fill_seq(input logic [7:0] base);
    for (int i = 0; i < FB; i++) fr[i] = base + 8'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < FB; i++) fr[i] = 8'($urandom);
  endtask

  task automatic set_ready(input logic v);
    ready_a = v;
    @(negedge clk);
    if (v) valid_m[0] = 1'b0;
  endtask

  task automatic check_all(input int sel, input string tag);
    settle();
    check($sformatf("%s_done", tag), 64'(cnt_done[sel]), 64'(exp_done[sel]));
    check($sformatf("%s_ovr", tag),  64'(cnt_ovr[sel]),  64'(exp_ovr[sel]));
    check($sformatf("%s_ferr", tag), 64'(cnt_ferr[sel]), 64'(exp_ferr[sel]));
    check($sformatf("%s_perr", tag), 64'(cnt_perr[sel]), 64'(exp_perr[sel]));
    check($sformatf("%s_tout", tag), 64'(cnt_tout[sel]), 64'(exp_tout[sel]));
    check($sformatf("%s_fdata", tag), (sel == 0) ? fdata_a : fdata_b, exp_fdata[sel]);
    check($sformatf("%s_valid", tag), (sel == 0) ? 64'(valid_a) : 64'(valid_b), 64'(valid_m[sel]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int d;
    int unsigned t_start;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_recept", 64'(recept_a), 64'd0);
    check("rst_fdata", fdata_a, 64'd0);
    check("rst_errs", 64'({ferr_a, perr_a, tout_a, ovr_a}), 64'd0);
    check("rst_b", 64'({valid_b, recept_b, done_b}), 64'd0);
    rst_n = 1'b1;
    idle_bits(0, 2);

    // Back-to-back frame 01..08 with ready held high.
    fill_seq(8'h01);
    send_frame(0, 0);
    check_all(0, "seq");
    check("seq_literal", fdata_a, 64'h0102030405060708);
    check("seq_recept_hold", 64'(rec_bad), 64'd0);
    check("seq_recept_end", 64'(recept_a), 64'd0);

    // Overrun with ready low, then a one-cycle accept.
    set_ready(1'b0);
    fill_seq(8'h01);
    send_frame(0, 0);
    check_all(0, "held");
    fill_seq(8'h11);
    send_frame(0, 0);
    check_all(0, "ovr");
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    valid_m[0] = 1'b0;
    check_all(0, "accept");
    set_ready(1'b1);

    // Framing error on byte 3, then a clean frame.
    fill_seq(8'h01);
    for (int i = 0; i <= 2; i++) send_byte(0, fr[i], i != 2, 1'b0, 0, 0);
    idle_bits(0, 2);
    check_all(0, "ferr");
    fill_seq(8'hAA);
    send_frame(0, 0);
    check_all(0, "after_ferr");
    check("after_ferr_literal", fdata_a, 64'hAAABACADAEAFB0B1);

    // Random framing-error positions.
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      k = $urandom_range(FB - 1, 0);
      for (int i = 0; i <= k; i++) send_byte(0, fr[i], i != k, 1'b0, 0, 0);
      idle_bits(0, 2);
      fill_rand();
      send_frame(0, 2);
      check_all(0, $sformatf("rferr%0d", r));
    end

    // Even parity instance: bad parity discards, good parity accepted.
    send_byte(1, 8'h03, 1'b1, 1'b1, 0, 0);
    idle_bits(1, 2);
    check_all(1, "perr");
    fill_rand();
    fr[0] = 8'h03;
    send_frame(1, 1);
    check_all(1, "par_ok");

    // Inter-byte timeout after three bytes.
    fill_rand();
    for (int i = 0; i < 2; i++) send_byte(0, fr[i], 1'b1, 1'b0, 0, 0);
    t_start = cyc;
    send_byte(0, fr[2], 1'b1, 1'b0, 0, 0);
    idle_bits(0, 25);
    check_all(0, "tout");
    d = int'(tout_cyc) - int'(t_start);
    check("tout_time", 64'((d >= int'(HALF + 9 * B + TO)) && (d <= int'(HALF + 9 * B + TO + 5))), 64'd1);
    check("tout_recept", 64'(recept_a), 64'd0);
    fill_rand();
    send_frame(0, 0);
    check_all(0, "after_tout");

    // Short low glitch must not produce a byte.
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    idle_bits(0, 2);
    check_all(0, "glitch");
    fill_rand();
    send_frame(0, 1);
    check_all(0, "after_glitch");

    // Asynchronous reset mid-byte while a frame is held.
    set_ready(1'b0);
    fill_rand();
    send_frame(0, 0);
    check_all(0, "pre_rst");
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(valid_a), 64'd0);
    check("mid_rst_fdata", fdata_a, 64'd0);
    check("mid_rst_recept", 64'(recept_a), 64'd0);
    rx_a = 1'b1;
    part_n = '{0, 0};
    valid_m = '{1'b0, 1'b0};
    exp_fdata = '{'0, '0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    idle_bits(0, 2);
    fill_rand();
    send_frame(0, 0);
    check_all(0, "after_rst");
    check_all(1, "b_after_rst");

    // Random frames with random ready level and inter-byte gaps.
    for (int r = 0; r < 4; r++) begin
      set_ready(1'($urandom_range(1, 0)));
      fill_rand();
      send_frame(0, 3);
      check_all(0, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
